// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port, synchronous-read RAM.
// Each grant takes one BUSY cycle (memory strobe) and one DONE cycle (ready pulse, read data).
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ready,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ready,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state;
  logic           prio;
  logic           owner;
  logic           cmd_we;
  logic [AW-1:2]  cmd_addr;
  logic [DW-1:0]  cmd_wdata;

  logic           req0_eff;
  logic           req1_eff;
  logic           grant;
  logic           winner;

  // In DONE the owner's req is still high by protocol, so it cannot win again back to back.
  always_comb begin
    req0_eff = m0_req && !((state == DONE) && (owner == 1'b0));
    req1_eff = m1_req && !((state == DONE) && (owner == 1'b1));
    grant    = (state != BUSY) && (req0_eff || req1_eff);
    winner   = (req0_eff && req1_eff) ? prio : req1_eff;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      prio      <= 1'b0;
      owner     <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (grant) begin
            state     <= BUSY;
            owner     <= winner;
            prio      <= ~winner;
            cmd_we    <= winner ? m1_we : m0_we;
            cmd_addr  <= winner ? m1_addr[AW-1:2] : m0_addr[AW-1:2];
            cmd_wdata <= winner ? m1_wdata : m0_wdata;
          end else begin
            state <= IDLE;
          end
        end
        BUSY:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs depend only on state and the latched command, never on live master inputs.
  assign mem_en    = (state == BUSY);
  assign mem_we    = mem_en && cmd_we;
  assign mem_addr  = {cmd_addr, 2'b00};
  assign mem_wdata = cmd_wdata;

  assign m0_ready  = (state == DONE) && (owner == 1'b0);
  assign m1_ready  = (state == DONE) && (owner == 1'b1);
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random two-master traffic,
// checked every cycle against a timing/round-robin reference model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req [2];
  logic        we [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic        m0_ready, m1_ready, mem_en, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] ram [256];
  logic [31:0] ref_mem [256];

  int          cyc, lg, n_chk, n_err, n_we;
  bit          chk_en, own, prio_m, we_l;
  logic [31:0] addr_l, wd_l, exp_rd;
  bit          pend [2];
  bit          drop [2];

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference rules: grant at cycle g -> memory access at g+1, ready at g+2; the
  // port is free again for the other master at g+2 and for anyone at g+3.
  task automatic grant_step();
    bit e0, e1, w;
    if (reset) begin
      lg = -100;
      prio_m = 1'b0;
      return;
    end
    e0 = 1'b0;
    e1 = 1'b0;
    if (cyc == lg + 2) begin
      e0 = req[0] && own;
      e1 = req[1] && !own;
    end else if (cyc >= lg + 3) begin
      e0 = req[0];
      e1 = req[1];
    end
    if (e0 || e1) begin
      w      = (e0 && e1) ? prio_m : e1;
      own    = w;
      we_l   = we[w];
      addr_l = addr[w];
      wd_l   = wdata[w];
      prio_m = !w;
      lg     = cyc;
    end
  endtask

  task automatic check_outputs();
    bit en_x, r0, r1;
    en_x = (cyc == lg + 1);
    r0   = (cyc == lg + 2) && !own;
    r1   = (cyc == lg + 2) && own;
    if (mem_we) n_we++;
    chk("mem_en", 32'(mem_en), 32'(en_x));
    if (en_x) begin
      chk("mem_we", 32'(mem_we), 32'(we_l));
      chk("mem_addr", mem_addr, {addr_l[31:2], 2'b00});
      if (we_l) begin
        chk("mem_wdata", mem_wdata, wd_l);
        ref_mem[addr_l[9:2]] = wd_l;
      end else begin
        exp_rd = ref_mem[addr_l[9:2]];
      end
    end else begin
      chk("mem_we_idle", 32'(mem_we), 32'(0));
    end
    chk("m0_ready", 32'(m0_ready), 32'(r0));
    chk("m1_ready", 32'(m1_ready), 32'(r1));
    if (r0 && !we_l) chk("m0_rdata", m0_rdata, exp_rd);
    if (r1 && !we_l) chk("m1_rdata", m1_rdata, exp_rd);
  endtask

  // One clock: model arbitrates on current inputs, the RAM answers the DUT's strobe,
  // then outputs of the new cycle are checked at the falling edge.
  task automatic tick();
    logic        en, wr;
    logic [31:0] a, d;
    en = mem_en;
    wr = mem_we;
    a  = mem_addr;
    d  = mem_wdata;
    grant_step();
    @(posedge clk);
    #1;
    if (en) begin
      if (wr) ram[a[9:2]] = d;
      else    mem_rdata = ram[a[9:2]];
    end
    @(negedge clk);
    cyc++;
    if (chk_en) check_outputs();
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    req[0] = 1'b0; req[1] = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    drop[0] = 1'b0; drop[1] = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_m0_ready", 32'(m0_ready), 32'(0));
    chk("rst_m1_ready", 32'(m1_ready), 32'(0));
    chk("rst_mem_en", 32'(mem_en), 32'(0));
    chk("rst_mem_we", 32'(mem_we), 32'(0));
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk_en = 1'b1;
  endtask

  task automatic new_cmd(input int i);
    we[i]    = 1'($urandom_range(0, 1));
    addr[i]  = $urandom_range(0, 127);
    wdata[i] = $urandom;
  endtask

  task automatic drive_rand(input int i);
    logic rdy;
    rdy = (i == 0) ? m0_ready : m1_ready;
    if (rdy) begin
      pend[i] = 1'b0;
      drop[i] = 1'b0;
    end
    if (!pend[i]) begin
      if ($urandom_range(0, 1) == 1) begin
        pend[i] = 1'b1;
        new_cmd(i);
      end
    end else if (!drop[i] && (own == (i == 1)) && (cyc == lg + 1) && ($urandom_range(0, 7) == 0)) begin
      drop[i] = 1'b1;
    end else if ($urandom_range(0, 3) == 0) begin
      new_cmd(i);
    end
    req[i] = pend[i] && !drop[i];
  endtask

  initial begin
    int k, last, w0;
    n_chk = 0; n_err = 0; n_we = 0; cyc = 0; lg = -100;
    chk_en = 1'b0; own = 1'b0; prio_m = 1'b0; we_l = 1'b0;
    addr_l = '0; wd_l = '0; exp_rd = '0; mem_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    for (int i = 0; i < 256; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[8'h10] = 32'hDEADBEEF;
    ref_mem[8'h10] = 32'hDEADBEEF;

    reset_dut();

    // single read by master 0
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h40;
    tick();
    chk("rd_en", 32'(mem_en), 32'(1));
    chk("rd_addr", mem_addr, 32'h40);
    chk("rd_m1_busy", 32'(m1_ready), 32'(0));
    tick();
    chk("rd_ready", 32'(m0_ready), 32'(1));
    chk("rd_data", m0_rdata, 32'hDEADBEEF);
    chk("rd_m1_done", 32'(m1_ready), 32'(0));
    req[0] = 1'b0;
    tick();

    // master 1 write to unaligned 0x47, then read back from 0x44
    w0 = n_we;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h47; wdata[1] = 32'h12345678;
    tick();
    chk("wr_addr", mem_addr, 32'h44);
    chk("wr_we", 32'(mem_we), 32'(1));
    tick();
    chk("wr_ready", 32'(m1_ready), 32'(1));
    we[1] = 1'b0; addr[1] = 32'h44;
    tick();
    tick();
    tick();
    chk("rb_ready", 32'(m1_ready), 32'(1));
    chk("rb_data", m1_rdata, 32'h12345678);
    chk("wr_we_cycles", 32'(n_we - w0), 32'(1));
    req[1] = 1'b0;
    tick();

    // command latching: address changes during BUSY must not reach memory
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
    tick();
    addr[0] = 32'h20;
    #1;
    chk("latch_addr", mem_addr, 32'h10);
    tick();
    chk("latch_ready", 32'(m0_ready), 32'(1));
    req[0] = 1'b0;
    tick();

    // request dropped after grant still completes
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h30;
    tick();
    req[0] = 1'b0;
    tick();
    chk("drop_ready", 32'(m0_ready), 32'(1));
    tick();
    chk("drop_idle_en", 32'(mem_en), 32'(0));
    chk("drop_idle_rdy", 32'(m0_ready), 32'(0));
    tick();

    // contention fairness from reset
    reset_dut();
    req[0] = 1'b1; req[1] = 1'b1; we[0] = 1'b0; we[1] = 1'b0;
    addr[0] = 32'h08; addr[1] = 32'h0C;
    k = 0; last = 0;
    for (int t = 0; t < 40 && k < 8; t++) begin
      tick();
      if (m0_ready || m1_ready) begin
        chk("fair_order", 32'(m1_ready), 32'(k % 2));
        if (k > 0) chk("fair_gap", 32'(cyc - last), 32'(2));
        last = cyc;
        k++;
      end
    end
    chk("fair_count", 32'(k), 32'(8));
    req[0] = 1'b0; req[1] = 1'b0;
    tick(); tick(); tick();

    // reset during BUSY of a write: write lands, no ready, prio back to master 0
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h80; wdata[0] = 32'hA5A5A5A5;
    tick();
    chk("rst_busy_we", 32'(mem_we), 32'(1));
    reset = 1'b1;
    req[0] = 1'b0;
    tick();
    reset = 1'b0;
    chk("rstop_ready", 32'(m0_ready), 32'(0));
    chk("rstop_en", 32'(mem_en), 32'(0));
    chk("rstop_addr", mem_addr, 32'h0);
    chk("rstop_mem", ram[8'h20], 32'hA5A5A5A5);
    tick();
    chk("rstop_noready0", 32'(m0_ready), 32'(0));
    chk("rstop_noready1", 32'(m1_ready), 32'(0));
    req[0] = 1'b1; req[1] = 1'b1; we[0] = 1'b0; we[1] = 1'b0;
    tick();
    tick();
    chk("rstop_prio_m0", 32'(m0_ready), 32'(1));
    chk("rstop_prio_m1", 32'(m1_ready), 32'(0));
    req[0] = 1'b0; req[1] = 1'b0;
    tick(); tick(); tick();

    // random traffic
    reset_dut();
    for (int t = 0; t < 3000; t++) begin
      drive_rand(0);
      drive_rand(1);
      tick();
    end
    req[0] = 1'b0; req[1] = 1'b0;
    for (int t = 0; t < 4; t++) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
